// File: rtl/clk_divider_bank.sv
// Bank of programmable clock-enable tick generators with 50% square outputs.
// Optional CLK_DIVIDER_BANK_SYNC_EN adds a sync input that phase-aligns all channels.

module clk_divider_bank_lane #(
   parameter int WIDTH        = 17,
   parameter int DEFAULT_RATE = 1000
) (
   input  logic             clk_input,
   input  logic             rst_input,
   input  logic             enable,
`ifdef CLK_DIVIDER_BANK_SYNC_EN
   input  logic             sync,
`endif
   input  logic             ld,
   input  logic [WIDTH-1:0] load_rate,
   output logic             tick,
   output logic             square,
   output logic             err
);
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rate_q, rate_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;
   logic             sq_q, sq_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] nxt_rate;
   logic             nxt_pend;
   logic             wrap;

   always_ff @(posedge clk_input or posedge rst_input) begin
      if (rst_input) begin
         cnt_q    <= '0;
         rate_q   <= WIDTH'(DEFAULT_RATE);
         shadow_q <= WIDTH'(DEFAULT_RATE);
         pend_q   <= 1'b0;
         tick_q   <= 1'b0;
         sq_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         rate_q   <= rate_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         tick_q   <= tick_d;
         sq_q     <= sq_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      // a load in the wrap cycle counts as already pending
      nxt_rate = ld ? load_rate : shadow_q;
      nxt_pend = ld | pend_q;
      wrap     = !err_q && (cnt_q == rate_q - WIDTH'(1));
      cnt_d    = cnt_q;
      rate_d   = rate_q;
      shadow_d = nxt_rate;
      pend_d   = nxt_pend;
      tick_d   = 1'b0;
      sq_d     = sq_q;
      err_d    = err_q;
`ifdef CLK_DIVIDER_BANK_SYNC_EN
      if (sync) begin
         cnt_d = '0;
         sq_d  = 1'b0;
         if (pend_q) begin
            rate_d = shadow_q;
            err_d  = (shadow_q == '0);
         end
         pend_d = ld;
      end else
`endif
      if (enable) begin
         if (err_q) begin
            // no wrap exists in error, so a pending value applies at once
            if (nxt_pend) begin
               rate_d = nxt_rate;
               err_d  = (nxt_rate == '0);
               pend_d = 1'b0;
            end
         end else if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = ~sq_q;
            if (nxt_pend) begin
               rate_d = nxt_rate;
               err_d  = (nxt_rate == '0);
               pend_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
         end
      end
   end

   assign tick   = tick_q;
   assign square = sq_q;
   assign err    = err_q;
endmodule

module clk_divider_bank #(
   parameter int WIDTH        = 17,
   parameter int CHANNELS     = 2,
   parameter int DEFAULT_RATE = 1000,
   localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk_input,
   input  logic                rst_input,
   input  logic                enable,
`ifdef CLK_DIVIDER_BANK_SYNC_EN
   input  logic                sync,
`endif
   input  logic                load,
   input  logic [CW-1:0]       load_chan,
   input  logic [WIDTH-1:0]    load_rate,
   output logic [CHANNELS-1:0] tick_output,
   output logic [CHANNELS-1:0] square_output,
   output logic [CHANNELS-1:0] rate_error
);
   logic [CHANNELS-1:0] ld;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      // out-of-range channel indices match no lane
      assign ld[i] = load && (32'(load_chan) == i);

      clk_divider_bank_lane #(
         .WIDTH        (WIDTH),
         .DEFAULT_RATE (DEFAULT_RATE)
      ) u_lane (
         .clk_input (clk_input),
         .rst_input (rst_input),
         .enable    (enable),
`ifdef CLK_DIVIDER_BANK_SYNC_EN
         .sync      (sync),
`endif
         .ld        (ld[i]),
         .load_rate (load_rate),
         .tick      (tick_output[i]),
         .square    (square_output[i]),
         .err       (rate_error[i])
      );
   end
endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed bench for clk_divider_bank (2 channels, width 17, default rate 1000).

module tb_clk_divider_bank;
   logic        clk_input = 1'b0;
   logic        rst_input;
   logic        enable;
   logic        load;
   logic [0:0]  load_chan;
   logic [16:0] load_rate;
   logic [1:0]  tick_output, square_output, rate_error;
`ifdef CLK_DIVIDER_BANK_SYNC_EN
   logic        sync = 1'b0;
`endif
   int n_chk = 0;
   int n_bad = 0;
   int tick0_cnt = 0;
   int snap;

   clk_divider_bank #(.WIDTH(17), .CHANNELS(2), .DEFAULT_RATE(1000)) dut (
      .clk_input     (clk_input),
      .rst_input     (rst_input),
      .enable        (enable),
`ifdef CLK_DIVIDER_BANK_SYNC_EN
      .sync          (sync),
`endif
      .load          (load),
      .load_chan     (load_chan),
      .load_rate     (load_rate),
      .tick_output   (tick_output),
      .square_output (square_output),
      .rate_error    (rate_error)
   );

   always #5 clk_input = ~clk_input;

   always @(negedge clk_input) if (tick_output[0]) tick0_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_input);
      #1;
   endtask

   task automatic do_load(input logic ch, input logic [16:0] r);
      load = 1'b1; load_chan = ch; load_rate = r;
      step(1);
      load = 1'b0;
   endtask

   initial begin
      rst_input = 1'b1; enable = 1'b0; load = 1'b0; load_chan = '0; load_rate = '0;
      #12;
      chk("rst_tick", 32'(tick_output), 32'h0);
      chk("rst_sq",   32'(square_output), 32'h0);
      chk("rst_err",  32'(rate_error), 32'h0);
      step(1);
      rst_input = 1'b0;
      step(2);
      chk("idle_tick", 32'(tick_output), 32'h0);

      // default rate 1000 on both channels
      enable = 1'b1;
      snap = tick0_cnt;
      step(999);  chk("t1_pre",   32'(tick_output), 32'h0);
      step(1);    chk("t1_1000",  32'(tick_output), 32'h3);
                  chk("t1_sq",    32'(square_output), 32'h3);
      step(1);    chk("t1_1001",  32'(tick_output), 32'h0);
      step(999);  chk("t1_2000",  32'(tick_output), 32'h3);
                  chk("t1_sq2",   32'(square_output), 32'h0);
      step(1000); chk("t1_3000",  32'(tick_output), 32'h3);
      #5;         chk("t1_count", 32'(tick0_cnt - snap), 32'd3);
      #1;

      // ch1 <- 5 at cycle 2 of a period: old period finishes at 4000
      step(1);
      do_load(1'b1, 17'd5);                 // edge 3002
      step(997);  chk("t2_pre",   32'(tick_output), 32'h0);
      step(1);    chk("t2_4000",  32'(tick_output), 32'h3);
      step(4);    chk("t2_4004",  32'(tick_output), 32'h0);
      step(1);    chk("t2_4005",  32'(tick_output), 32'h2);
                  chk("t2_sq",    32'(square_output), 32'h2);
      step(5);    chk("t2_4010",  32'(tick_output), 32'h2);

      // rate 1 applies after the 4015 wrap
      do_load(1'b1, 17'd1);                 // edge 4011
      step(3);    chk("t3_4014",  32'(tick_output), 32'h0);
      step(1);    chk("t3_4015",  32'(tick_output), 32'h2);
                  chk("t3_sq0",   32'(square_output), 32'h2);
      step(1);    chk("t3_4016",  32'(tick_output), 32'h2);
                  chk("t3_sq1",   32'(square_output), 32'h0);
      step(1);    chk("t3_4017",  32'(tick_output), 32'h2);
                  chk("t3_sq2",   32'(square_output), 32'h2);

      // load 0 in a wrap cycle -> error, then recover with 3
      do_load(1'b1, 17'd0);                 // edge 4018
      chk("t4_err",   32'(rate_error), 32'h2);
      step(1);    chk("t4_notick", 32'(tick_output), 32'h0);
      step(5);    chk("t4_hold",  32'(tick_output), 32'h0);
                  chk("t4_errh",  32'(rate_error), 32'h2);
                  chk("t4_sq",    32'(square_output), 32'h0);
      do_load(1'b1, 17'd3);                 // edge 4025
      chk("t4_clr",   32'(rate_error), 32'h0);
      step(2);    chk("t4_4027",  32'(tick_output), 32'h0);
      step(1);    chk("t4_4028",  32'(tick_output), 32'h2);
      step(3);    chk("t4_4031",  32'(tick_output), 32'h2);

      // rate 10, enable low for 7 cycles mid-count
      do_load(1'b1, 17'd10);                // edge 4032
      step(2);    chk("t5_4034",  32'(tick_output), 32'h2);
      step(3);
      enable = 1'b0;
      step(7);    chk("t5_off",   32'(tick_output), 32'h0);
                  chk("t5_sqh",   32'(square_output), 32'h2);
      enable = 1'b1;
      step(1);
      do_load(1'b0, 17'd7);                 // edge 4046, left pending for reset
      step(4);    chk("t5_4050",  32'(tick_output), 32'h0);
      step(1);    chk("t5_4051",  32'(tick_output), 32'h2);
                  chk("t5_sq",    32'(square_output), 32'h0);

      // async reset between edges; pending ch0=7 must be dropped
      #3 rst_input = 1'b1;
      #1;
      chk("t6_tick",  32'(tick_output), 32'h0);
      chk("t6_err",   32'(rate_error), 32'h0);
      step(1);
      rst_input = 1'b0;
      step(999);  chk("t6_pre",   32'(tick_output), 32'h0);
      step(1);    chk("t6_1000",  32'(tick_output), 32'h3);
      step(7);    chk("t6_1007",  32'(tick_output), 32'h0);

`ifdef CLK_DIVIDER_BANK_SYNC_EN
      do_load(1'b0, 17'd4);
      do_load(1'b1, 17'd6);
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      chk("s_sq",  32'(square_output), 32'h0);
      step(3);    chk("s_3",  32'(tick_output), 32'h0);
      step(1);    chk("s_4",  32'(tick_output), 32'h1);
      step(2);    chk("s_6",  32'(tick_output), 32'h2);
      step(2);    chk("s_8",  32'(tick_output), 32'h1);
      step(4);    chk("s_12", 32'(tick_output), 32'h3);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
